// File: rtl/track_distinct.sv
// Tracks the most recent DEPTH distinct sample values, newest in slot 0.
// Hits either promote the value to the front (MTF) or leave order untouched (first-occurrence order).
module track_distinct #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned ZERO_IS_DATA = 0,
   localparam int unsigned IDX_W       = $clog2(DEPTH),
   localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
   input  logic                      clk_in,
   input  logic                      reset_n_in,
   input  logic                      valid_in,
   input  logic [DATA_W-1:0]         data_in,
   input  logic                      mode_in,
   input  logic                      flush_in,
   output logic [DEPTH*DATA_W-1:0]   out_data,
   output logic [DEPTH-1:0]          out_valid,
   output logic [CNT_W-1:0]          count_out,
   output logic                      hit_out,
   output logic [IDX_W-1:0]          hit_idx_out,
   output logic                      evict_valid_out,
   output logic [DATA_W-1:0]         evict_data_out
);

   logic [DEPTH-1:0][DATA_W-1:0] r_slot;
   logic [DEPTH-1:0]             r_valid;
   logic [CNT_W-1:0]             r_count;
   logic                         r_hit;
   logic [IDX_W-1:0]             r_hit_idx;
   logic                         r_evict_v;
   logic [DATA_W-1:0]            r_evict_d;

   logic [DEPTH-1:0][DATA_W-1:0] w_slot_nxt;
   logic [DEPTH-1:0]             w_valid_nxt;
   logic [CNT_W-1:0]             w_count_nxt;
   logic                         w_hit_nxt;
   logic [IDX_W-1:0]             w_hit_idx_nxt;
   logic                         w_evict_v_nxt;
   logic [DATA_W-1:0]            w_evict_d_nxt;

   logic [DEPTH-1:0]             w_match;
   logic                         w_hit;
   logic [IDX_W-1:0]             w_hit_idx;
   logic                         w_accept;

   assign w_accept = valid_in && !flush_in && ((ZERO_IS_DATA != 0) || (data_in != '0));

   // Only valid slots may match; contents are duplicate-free so at most one bit is set.
   always_comb begin
      w_match   = '0;
      w_hit_idx = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         w_match[i] = r_valid[i] && (r_slot[i] == data_in);
         if (w_match[i]) w_hit_idx = IDX_W'(i);
      end
      w_hit = |w_match;
   end

   always_comb begin
      w_slot_nxt    = r_slot;
      w_valid_nxt   = r_valid;
      w_count_nxt   = r_count;
      w_hit_nxt     = 1'b0;
      w_hit_idx_nxt = '0;
      w_evict_v_nxt = 1'b0;
      w_evict_d_nxt = '0;
      if (w_accept) begin
         if (w_hit) begin
            w_hit_nxt     = 1'b1;
            w_hit_idx_nxt = w_hit_idx;
            if (!mode_in) begin
               // Slots above the hit index keep their place; those at or below shift down.
               for (int i = 1; i < int'(DEPTH); i++) begin
                  if (IDX_W'(i) <= w_hit_idx) w_slot_nxt[i] = r_slot[i-1];
               end
               w_slot_nxt[0] = data_in;
            end
         end else begin
            for (int i = 1; i < int'(DEPTH); i++) begin
               w_slot_nxt[i] = r_slot[i-1];
            end
            w_slot_nxt[0] = data_in;
            w_valid_nxt   = {r_valid[DEPTH-2:0], 1'b1};
            if (r_valid[DEPTH-1]) begin
               w_evict_v_nxt = 1'b1;
               w_evict_d_nxt = r_slot[DEPTH-1];
            end else begin
               w_count_nxt = r_count + CNT_W'(1);
            end
         end
      end
   end

   // Reset and flush both clear everything; neither produces an eviction pulse.
   always_ff @(posedge clk_in) begin
      if (!reset_n_in || flush_in) begin
         r_slot    <= '0;
         r_valid   <= '0;
         r_count   <= '0;
         r_hit     <= 1'b0;
         r_hit_idx <= '0;
         r_evict_v <= 1'b0;
         r_evict_d <= '0;
      end else begin
         r_slot    <= w_slot_nxt;
         r_valid   <= w_valid_nxt;
         r_count   <= w_count_nxt;
         r_hit     <= w_hit_nxt;
         r_hit_idx <= w_hit_idx_nxt;
         r_evict_v <= w_evict_v_nxt;
         r_evict_d <= w_evict_d_nxt;
      end
   end

   assign out_data        = r_slot;
   assign out_valid       = r_valid;
   assign count_out       = r_count;
   assign hit_out         = r_hit;
   assign hit_idx_out     = r_hit_idx;
   assign evict_valid_out = r_evict_v;
   assign evict_data_out  = r_evict_d;

endmodule

// File: tb/tb_track_distinct.sv
// Directed bench for track_distinct: DEPTH=4, DATA_W=8, one instance per ZERO_IS_DATA setting.
module tb_track_distinct;

   logic        clk_in = 1'b0;
   logic        reset_n_in, valid_in, mode_in, flush_in;
   logic [7:0]  data_in;

   logic [31:0] d0_data,  d1_data;
   logic [3:0]  d0_valid, d1_valid;
   logic [2:0]  d0_count, d1_count;
   logic        d0_hit,   d1_hit;
   logic [1:0]  d0_idx,   d1_idx;
   logic        d0_ev,    d1_ev;
   logic [7:0]  d0_evd,   d1_evd;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk_in = ~clk_in;

   track_distinct #(.DATA_W(8), .DEPTH(4), .ZERO_IS_DATA(0)) u_dut0 (
      .clk_in(clk_in), .reset_n_in(reset_n_in), .valid_in(valid_in), .data_in(data_in),
      .mode_in(mode_in), .flush_in(flush_in), .out_data(d0_data), .out_valid(d0_valid),
      .count_out(d0_count), .hit_out(d0_hit), .hit_idx_out(d0_idx),
      .evict_valid_out(d0_ev), .evict_data_out(d0_evd));

   track_distinct #(.DATA_W(8), .DEPTH(4), .ZERO_IS_DATA(1)) u_dut1 (
      .clk_in(clk_in), .reset_n_in(reset_n_in), .valid_in(valid_in), .data_in(data_in),
      .mode_in(mode_in), .flush_in(flush_in), .out_data(d1_data), .out_valid(d1_valid),
      .count_out(d1_count), .hit_out(d1_hit), .hit_idx_out(d1_idx),
      .evict_valid_out(d1_ev), .evict_data_out(d1_evd));

   // One clock edge with the given inputs; outputs are sampled 1ns after the edge.
   task automatic step(input logic v, input logic [7:0] d, input logic m, input logic f);
      valid_in = v; data_in = d; mode_in = m; flush_in = f;
      @(posedge clk_in);
      #1;
      valid_in = 1'b0; flush_in = 1'b0;
   endtask

   task automatic test_reset();
      reset_n_in = 1'b0;
      repeat (3) step(1'b1, 8'd9, 1'b0, 1'b0);
      n_total++; if ({d0_data, d0_valid, d0_count, d0_hit, d0_idx, d0_ev, d0_evd} !== 58'd0)
         $display("FAIL reset_outputs got data=%h valid=%b cnt=%0d", d0_data, d0_valid, d0_count); else n_pass++;
      reset_n_in = 1'b1;
      step(1'b1, 8'd3, 1'b0, 1'b0);
      n_total++; if (d0_data !== 32'h00000003 || d0_count !== 3'd1)
         $display("FAIL reset_first_accept got data=%h cnt=%0d exp 00000003 1", d0_data, d0_count); else n_pass++;
      step(1'b0, 8'd0, 1'b0, 1'b1);
   endtask

   task automatic test_mtf_alternate();
      logic [7:0] seq [7] = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2, 8'd1};
      foreach (seq[i]) step(1'b1, seq[i], 1'b0, 1'b0);
      n_total++; if (d0_data !== 32'h00000201 || d0_valid !== 4'b0011 || d0_count !== 3'd2)
         $display("FAIL mtf_alt_slots got data=%h valid=%b cnt=%0d", d0_data, d0_valid, d0_count); else n_pass++;
      n_total++; if (d0_hit !== 1'b1 || d0_idx !== 2'd1)
         $display("FAIL mtf_alt_hit got hit=%b idx=%0d exp 1 1", d0_hit, d0_idx); else n_pass++;
      step(1'b0, 8'd0, 1'b0, 1'b1);
   endtask

   task automatic test_mtf_reorder();
      logic [7:0] seq [10] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd3, 8'd4, 8'd3, 8'd4};
      int n_ev = 0;
      foreach (seq[i]) begin
         step(1'b1, seq[i], 1'b0, 1'b0);
         if (d0_ev) n_ev++;
         if (i == 5) begin
            n_total++; if (d0_data !== 32'h01040302 || d0_idx !== 2'd2)
               $display("FAIL mtf_mid_hit got data=%h idx=%0d exp 01040302 2", d0_data, d0_idx); else n_pass++;
         end
      end
      n_total++; if (d0_data !== 32'h01020304 || d0_valid !== 4'b1111 || d0_count !== 3'd4)
         $display("FAIL mtf_reorder_slots got data=%h valid=%b cnt=%0d", d0_data, d0_valid, d0_count); else n_pass++;
      n_total++; if (n_ev !== 0)
         $display("FAIL mtf_reorder_evict got %0d pulses exp 0", n_ev); else n_pass++;
      step(1'b0, 8'd0, 1'b0, 1'b1);
   endtask

   task automatic test_evict();
      for (int m = 0; m < 2; m++) begin
         for (int s = 1; s <= 6; s++) begin
            step(1'b1, 8'(s), 1'(m), 1'b0);
            if (s == 4) begin
               n_total++; if (d0_ev !== 1'b0 || d0_count !== 3'd4)
                  $display("FAIL evict_full_no_pulse mode%0d got ev=%b cnt=%0d", m, d0_ev, d0_count); else n_pass++;
            end
            if (s >= 5) begin
               n_total++; if (d0_ev !== 1'b1 || d0_evd !== 8'(s - 4))
                  $display("FAIL evict_pulse mode%0d s%0d got ev=%b data=%0d exp 1 %0d", m, s, d0_ev, d0_evd, s - 4); else n_pass++;
            end
         end
         n_total++; if (d0_data !== 32'h03040506 || d0_count !== 3'd4)
            $display("FAIL evict_slots mode%0d got data=%h cnt=%0d", m, d0_data, d0_count); else n_pass++;
         step(1'b0, 8'd0, 1'b0, 1'b0);
         n_total++; if (d0_ev !== 1'b0 || d0_evd !== 8'd0)
            $display("FAIL evict_one_cycle mode%0d got ev=%b data=%0d", m, d0_ev, d0_evd); else n_pass++;
         step(1'b0, 8'd0, 1'b0, 1'b1);
      end
   endtask

   task automatic test_fifo_distinct();
      step(1'b1, 8'd1, 1'b1, 1'b0);
      step(1'b1, 8'd2, 1'b1, 1'b0);
      step(1'b1, 8'd3, 1'b1, 1'b0);
      step(1'b1, 8'd1, 1'b1, 1'b0);
      n_total++; if (d0_data !== 32'h00010203 || d0_count !== 3'd3 || d0_valid !== 4'b0111)
         $display("FAIL fifo_slots got data=%h valid=%b cnt=%0d", d0_data, d0_valid, d0_count); else n_pass++;
      n_total++; if (d0_hit !== 1'b1 || d0_idx !== 2'd2)
         $display("FAIL fifo_hit got hit=%b idx=%0d exp 1 2", d0_hit, d0_idx); else n_pass++;
      // Toggling mode while idle must not disturb contents.
      step(1'b0, 8'd0, 1'b0, 1'b0);
      step(1'b0, 8'd0, 1'b1, 1'b0);
      n_total++; if (d0_data !== 32'h00010203 || d0_hit !== 1'b0)
         $display("FAIL mode_toggle_idle got data=%h hit=%b", d0_data, d0_hit); else n_pass++;
      step(1'b0, 8'd0, 1'b0, 1'b1);
   endtask

   task automatic test_zero_data();
      step(1'b1, 8'd0, 1'b0, 1'b0);
      n_total++; if (d1_hit !== 1'b0 || d1_count !== 3'd1 || d0_count !== 3'd0)
         $display("FAIL zero_first got d1 hit=%b cnt=%0d d0 cnt=%0d", d1_hit, d1_count, d0_count); else n_pass++;
      step(1'b1, 8'd5, 1'b0, 1'b0);
      step(1'b1, 8'd0, 1'b0, 1'b0);
      n_total++; if (d0_data !== 32'h00000005 || d0_count !== 3'd1 || d0_hit !== 1'b0)
         $display("FAIL zero_dropped got data=%h cnt=%0d hit=%b", d0_data, d0_count, d0_hit); else n_pass++;
      n_total++; if (d1_data !== 32'h00000500 || d1_valid !== 4'b0011 || d1_count !== 3'd2 || d1_hit !== 1'b1 || d1_idx !== 2'd1)
         $display("FAIL zero_is_data got data=%h valid=%b cnt=%0d hit=%b idx=%0d", d1_data, d1_valid, d1_count, d1_hit, d1_idx); else n_pass++;
      step(1'b1, 8'd0, 1'b0, 1'b0);
      n_total++; if (d1_data !== 32'h00000500 || d1_hit !== 1'b1 || d1_idx !== 2'd0)
         $display("FAIL hit_slot0 got data=%h hit=%b idx=%0d", d1_data, d1_hit, d1_idx); else n_pass++;
      step(1'b0, 8'd0, 1'b0, 1'b1);
   endtask

   task automatic test_flush_reset_hold();
      step(1'b1, 8'd7, 1'b0, 1'b0);
      step(1'b1, 8'd8, 1'b0, 1'b0);
      step(1'b1, 8'd9, 1'b0, 1'b0);
      step(1'b1, 8'd4, 1'b0, 1'b1);
      n_total++; if ({d0_data, d0_valid, d0_count, d0_hit, d0_idx, d0_ev, d0_evd} !== 58'd0)
         $display("FAIL flush_clears got data=%h valid=%b cnt=%0d", d0_data, d0_valid, d0_count); else n_pass++;
      step(1'b1, 8'd7, 1'b0, 1'b0);
      step(1'b1, 8'd8, 1'b0, 1'b0);
      step(1'b1, 8'd7, 1'b0, 1'b0);
      repeat (3) step(1'b0, 8'd8, 1'b1, 1'b0);
      n_total++; if (d0_data !== 32'h00000807 || d0_count !== 3'd2 || d0_hit !== 1'b0 || d0_ev !== 1'b0)
         $display("FAIL idle_hold got data=%h cnt=%0d hit=%b", d0_data, d0_count, d0_hit); else n_pass++;
      step(1'b1, 8'd1, 1'b0, 1'b0);
      step(1'b1, 8'd2, 1'b0, 1'b0);
      reset_n_in = 1'b0;
      step(1'b1, 8'd3, 1'b0, 1'b0);
      n_total++; if ({d0_data, d0_valid, d0_count, d0_hit, d0_idx, d0_ev, d0_evd} !== 58'd0)
         $display("FAIL reset_midstream got data=%h cnt=%0d ev=%b", d0_data, d0_count, d0_ev); else n_pass++;
      reset_n_in = 1'b1;
   endtask

   initial begin
      reset_n_in = 1'b0; valid_in = 1'b0; data_in = 8'd0; mode_in = 1'b0; flush_in = 1'b0;
      test_reset();
      test_mtf_alternate();
      test_mtf_reorder();
      test_evict();
      test_fifo_distinct();
      test_zero_data();
      test_flush_reset_hold();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
